// File: rtl/execute_stage_pkg.sv
// Shared opcode constants and packed-word field helpers for the
// decode/execute pipeline.
package execute_stage_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_MOV_SR = 4'h1;
    localparam logic [3:0] OP_ADD_SR = 4'h2;

    localparam int OPC_W   = 4;
    localparam int OPC_LSB = 0;
    localparam int ADR_LSB = OPC_W;

endpackage

// File: rtl/execute_stage_if.sv
// Data RAM request/grant bus between the execute stage (master)
// and the RAM arbiter (slave).
interface execute_stage_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12
) ();

    logic              ram_rd;
    logic              ram_wr;
    logic              ram_garant;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_out;
    logic [DATA_W-1:0] ram_data_in;

    modport master (
        output ram_rd, ram_wr, ram_addr, ram_data_out,
        input  ram_garant, ram_data_in
    );

    modport slave (
        input  ram_rd, ram_wr, ram_addr, ram_data_out,
        output ram_garant, ram_data_in
    );

endinterface

// File: rtl/execute_stage_fifo.sv
// exec_fifo: parameterised input buffer with count and full/empty flags.
// count_next exposes the post-edge occupancy for registered throttling.
module exec_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [AW:0]      count_next
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign count_next = count_d;

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by natural overflow
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/execute_stage.sv
// Execute/write-back stage: buffers decoded ops and runs them against data RAM.
// Define EXEC_RMW_EN to enable the OP_ADD_SR read-modify-write path.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int WORD_W    = DATA_W + ADDR_W + 4,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] complex_data,
    input  logic              data_write,
    output logic              pause_DECODE,
    execute_stage_if.master   ram,
    output logic              busy,
    output logic              retired,
    output logic              err_illegal,
    output logic              err_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_RD_REQ,
        S_WR_REQ,
        S_DONE
    } state_e;

    localparam int DAT_LSB = ADDR_W + 4;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ram_rd_q, ram_rd_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_dout_q, ram_dout_d;
    logic              retired_q, retired_d;
    logic              err_ill_q, err_ill_d;
    logic              err_ovf_q, err_ovf_d;
    logic              pause_q, pause_d;

    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count, fifo_count_next;

    exec_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (data_write),
        .pop        (fifo_pop),
        .wdata      (complex_data),
        .rdata      (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

`ifndef EXEC_RMW_EN
    logic unused_rd_data;
    assign unused_rd_data = ^ram.ram_data_in;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ram_rd_d   = ram_rd_q;
        ram_wr_d   = ram_wr_q;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        err_ill_d  = err_ill_q;
        fifo_pop   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_head[OPC_LSB +: OPC_W];
                    addr_d   = fifo_head[ADR_LSB +: ADDR_W];
                    data_d   = fifo_head[DAT_LSB +: DATA_W];
                    state_d  = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                case (op_q)
                    OP_NOP: state_d = S_DONE;
                    OP_MOV_SR: begin
                        ram_wr_d   = 1'b1;
                        ram_addr_d = addr_q;
                        ram_dout_d = data_q;
                        state_d    = S_WR_REQ;
                    end
`ifdef EXEC_RMW_EN
                    OP_ADD_SR: begin
                        ram_rd_d   = 1'b1;
                        ram_addr_d = addr_q;
                        state_d    = S_RD_REQ;
                    end
`endif
                    default: begin
                        err_ill_d = 1'b1;
                        state_d   = S_DONE;
                    end
                endcase
            end
`ifdef EXEC_RMW_EN
            S_RD_REQ: begin
                // Sum wraps at DATA_W bits; address stays put for the write
                if (ram.ram_garant) begin
                    ram_rd_d   = 1'b0;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = ram.ram_data_in + data_q;
                    state_d    = S_WR_REQ;
                end
            end
`endif
            S_WR_REQ: begin
                if (ram.ram_garant) begin
                    ram_wr_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        retired_d = (state_d == S_DONE);
        err_ovf_d = err_ovf_q | (data_write & fifo_full);
        // One slot stays free for a word already in flight
        pause_d   = (fifo_count_next >= CW'(FIFO_DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            retired_q  <= 1'b0;
            err_ill_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            pause_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ram_rd_q   <= ram_rd_d;
            ram_wr_q   <= ram_wr_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            retired_q  <= retired_d;
            err_ill_q  <= err_ill_d;
            err_ovf_q  <= err_ovf_d;
            pause_q    <= pause_d;
        end
    end

    assign ram.ram_rd       = ram_rd_q;
    assign ram.ram_wr       = ram_wr_q;
    assign ram.ram_addr     = ram_addr_q;
    assign ram.ram_data_out = ram_dout_q;
    assign pause_DECODE     = pause_q;
    assign retired          = retired_q;
    assign err_illegal      = err_ill_q;
    assign err_overflow     = err_ovf_q;
    assign busy             = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, multi-cycle sequences
// and a randomized run against a transaction-level reference model.
module tb_execute_stage;
    import execute_stage_pkg::*;

    localparam int DW = 14;
    localparam int AW = 12;
    localparam int WW = DW + AW + 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [WW-1:0] complex_data;
    logic          data_write;
    logic          pause_DECODE, busy, retired, err_illegal, err_overflow;

    execute_stage_if #(.DATA_W(DW), .ADDR_W(AW)) ram_if ();

    execute_stage #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .complex_data (complex_data),
        .data_write   (data_write),
        .pause_DECODE (pause_DECODE),
        .ram          (ram_if),
        .busy         (busy),
        .retired      (retired),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

`ifdef EXEC_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    int vecs = 0;
    int errs = 0;

    typedef struct {
        string          name;
        logic [3:0]     op;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [DW-1:0]  rdata;
        int             dly;
        int             e_rd;
        int             e_wr;
        logic [DW-1:0]  e_wdata;
        int             e_ret;
        logic           e_ill;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] pack(input logic [3:0] op,
                                           input logic [AW-1:0] a,
                                           input logic [DW-1:0] d);
        return {d, a, op};
    endfunction

    function automatic bit writes_ram(input logic [3:0] op);
        return (op == OP_MOV_SR) || (RMW && op == OP_ADD_SR);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        data_write = 1'b0;
        complex_data = '0;
        ram_if.ram_garant = 1'b0;
        ram_if.ram_data_in = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int first_rd, first_wr, ret, ret_cnt, wr_cnt, req_len;
        logic [AW-1:0] waddr, raddr;
        logic [DW-1:0] wdata;
        logic [1:0] cur, prev;
        bit stable, both;
        do_reset();
        complex_data = pack(v.op, v.addr, v.data);
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
        first_rd = 0; first_wr = 0; ret = 0; ret_cnt = 0; wr_cnt = 0;
        req_len = 0; prev = 2'b00; stable = 1; both = 0;
        waddr = '0; raddr = '0; wdata = '0;
        for (int c = 1; c <= 40; c++) begin
            cur = {ram_if.ram_rd, ram_if.ram_wr};
            if (cur != prev) req_len = 0;
            if (ram_if.ram_rd && first_rd == 0) begin
                first_rd = c;
                raddr = ram_if.ram_addr;
            end
            if (ram_if.ram_wr) begin
                if (first_wr == 0) begin
                    first_wr = c;
                    wdata = ram_if.ram_data_out;
                    waddr = ram_if.ram_addr;
                end else if (ram_if.ram_data_out !== wdata ||
                             ram_if.ram_addr !== waddr) begin
                    stable = 0;
                end
                wr_cnt++;
            end
            if (&cur) both = 1;
            if (retired) begin
                ret_cnt++;
                if (ret == 0) ret = c;
            end
            ram_if.ram_garant = (cur != 2'b00) && (req_len >= v.dly);
            ram_if.ram_data_in = v.rdata;
            req_len++;
            prev = cur;
            tick();
        end
        ram_if.ram_garant = 1'b0;
        check({v.name, " rd_cycle"}, first_rd, v.e_rd);
        if (v.e_rd != 0) check({v.name, " rd_addr"}, raddr, v.addr);
        check({v.name, " wr_cycle"}, first_wr, v.e_wr);
        if (v.e_wr != 0) begin
            check({v.name, " wr_addr"}, waddr, v.addr);
            check({v.name, " wr_data"}, wdata, v.e_wdata);
            check({v.name, " wr_len"}, wr_cnt, v.dly + 1);
            check({v.name, " wr_stable"}, stable, 1);
        end else begin
            check({v.name, " wr_len"}, wr_cnt, 0);
        end
        check({v.name, " ret_cycle"}, ret, v.e_ret);
        check({v.name, " ret_count"}, ret_cnt, 1);
        check({v.name, " err_illegal"}, err_illegal, v.e_ill);
        check({v.name, " rd_wr_both"}, both, 0);
        check({v.name, " busy_end"}, busy, 0);
    endtask

    task automatic seq_overflow();
        logic [WW-1:0] w[6];
        logic [AW-1:0] q_addr[$];
        logic [DW-1:0] q_data[$];
        int rets;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            w[k] = pack(OP_MOV_SR, AW'(k + 1), DW'(16'h100 + k));
            complex_data = w[k];
            data_write = 1'b1;
            tick();
            check($sformatf("ovf pause_after_push%0d", k + 1),
                  pause_DECODE, (k + 1 >= 4));
            check($sformatf("ovf err_after_push%0d", k + 1),
                  err_overflow, (k == 5));
        end
        data_write = 1'b0;
        rets = 0;
        for (int c = 0; c < 60; c++) begin
            ram_if.ram_garant = ram_if.ram_wr | ram_if.ram_rd;
            if (ram_if.ram_wr) begin
                q_addr.push_back(ram_if.ram_addr);
                q_data.push_back(ram_if.ram_data_out);
            end
            if (retired) rets++;
            tick();
        end
        ram_if.ram_garant = 1'b0;
        check("ovf retired_count", rets, 5);
        check("ovf write_count", q_addr.size(), 5);
        for (int k = 0; k < 5 && k < q_addr.size(); k++) begin
            check($sformatf("ovf wr%0d_addr", k), q_addr[k], k + 1);
            check($sformatf("ovf wr%0d_data", k), q_data[k], 16'h100 + k);
        end
        check("ovf err_sticky", err_overflow, 1);
        check("ovf busy_end", busy, 0);
    endtask

    task automatic seq_reset_mid();
        int seen, late;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            complex_data = pack((k == 0 && RMW) ? OP_ADD_SR : OP_MOV_SR,
                                AW'(12'h200 + k), DW'(k + 7));
            data_write = 1'b1;
            tick();
        end
        data_write = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            if (ram_if.ram_rd | ram_if.ram_wr) seen = 1;
            else tick();
        end
        check("rst_mid req_seen", seen, 1);
        check("rst_mid rd_high", ram_if.ram_rd, RMW);
        reset = 1'b1;
        tick();
        check("rst_mid ram_rd", ram_if.ram_rd, 0);
        check("rst_mid ram_wr", ram_if.ram_wr, 0);
        check("rst_mid ram_addr", ram_if.ram_addr, 0);
        check("rst_mid ram_data", ram_if.ram_data_out, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid pause", pause_DECODE, 0);
        check("rst_mid retired", retired, 0);
        reset = 1'b0;
        late = 0;
        ram_if.ram_garant = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (ram_if.ram_rd | ram_if.ram_wr | retired) late++;
            tick();
        end
        ram_if.ram_garant = 1'b0;
        check("rst_mid no_exec", late, 0);
    endtask

    task automatic rand_run();
        logic [WW-1:0] exp_q[$];
        logic [WW-1:0] w, head;
        logic [DW-1:0] rd_val, exp_d;
        logic [3:0] op;
        bit got_wr, any_ill;
        int pushed, r;
        do_reset();
        pushed = 0; got_wr = 0; any_ill = 0; rd_val = '0;
        for (int cyc = 0; cyc < 4000 &&
             (pushed < 150 || exp_q.size() > 0); cyc++) begin
            data_write = 1'b0;
            if (pushed < 150 && !pause_DECODE && $urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 5);
                case (r)
                    0: op = OP_NOP;
                    1, 2: op = OP_MOV_SR;
                    3, 4: op = OP_ADD_SR;
                    default: op = 4'($urandom);
                endcase
                w = pack(op, AW'($urandom), DW'($urandom));
                complex_data = w;
                data_write = 1'b1;
                exp_q.push_back(w);
                pushed++;
                if (op != OP_NOP && !writes_ram(op)) any_ill = 1;
            end
            ram_if.ram_garant = (ram_if.ram_rd | ram_if.ram_wr) &&
                                ($urandom_range(0, 2) != 0);
            ram_if.ram_data_in = DW'($urandom);
            if (ram_if.ram_rd && ram_if.ram_wr) check("rnd rd_wr_both", 1, 0);
            head = (exp_q.size() > 0) ? exp_q[0] : '0;
            if ((ram_if.ram_rd | ram_if.ram_wr | retired) &&
                exp_q.size() == 0)
                check("rnd activity_with_empty_model", 1, 0);
            if (ram_if.ram_rd && ram_if.ram_garant) begin
                check("rnd rd_op", head[3:0], OP_ADD_SR);
                check("rnd rd_addr", ram_if.ram_addr, head[AW+3:4]);
                rd_val = ram_if.ram_data_in;
            end
            if (ram_if.ram_wr && ram_if.ram_garant) begin
                exp_d = head[WW-1:AW+4];
                if (head[3:0] == OP_ADD_SR) exp_d = exp_d + rd_val;
                check("rnd wr_addr", ram_if.ram_addr, head[AW+3:4]);
                check("rnd wr_data", ram_if.ram_data_out, exp_d);
                got_wr = 1;
            end
            if (retired && exp_q.size() > 0) begin
                check("rnd wrote_ram", got_wr, writes_ram(head[3:0]));
                void'(exp_q.pop_front());
                got_wr = 0;
            end
            tick();
        end
        data_write = 1'b0;
        ram_if.ram_garant = 1'b0;
        check("rnd drained", exp_q.size(), 0);
        check("rnd pushed", pushed, 150);
        check("rnd err_illegal", err_illegal, any_ill);
        check("rnd err_overflow", err_overflow, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{"mov_basic", OP_MOV_SR, 12'h0F0, 14'h1ABC, 14'h0, 0,
                   0, 3, 14'h1ABC, 4, 1'b0};
        tbl[1] = '{"mov_gnt1", OP_MOV_SR, 12'hFFF, 14'h0000, 14'h0, 1,
                   0, 3, 14'h0000, 5, 1'b0};
        tbl[2] = '{"mov_stall5", OP_MOV_SR, 12'h000, 14'h3FFF, 14'h0, 5,
                   0, 3, 14'h3FFF, 9, 1'b0};
        tbl[3] = RMW ?
            '{"add_wrap", OP_ADD_SR, 12'h010, 14'h0005, 14'h3FFE, 0,
              3, 4, 14'h0003, 5, 1'b0} :
            '{"add_wrap", OP_ADD_SR, 12'h010, 14'h0005, 14'h3FFE, 0,
              0, 0, 14'h0, 3, 1'b1};
        tbl[4] = RMW ?
            '{"add_stall2", OP_ADD_SR, 12'hABC, 14'h1234, 14'h0F00, 2,
              3, 6, 14'h2134, 9, 1'b0} :
            '{"add_stall2", OP_ADD_SR, 12'hABC, 14'h1234, 14'h0F00, 2,
              0, 0, 14'h0, 3, 1'b1};
        tbl[5] = '{"nop", OP_NOP, 12'h123, 14'h0321, 14'h0, 0,
                   0, 0, 14'h0, 3, 1'b0};
        tbl[6] = '{"illegal_f", 4'hF, 12'h055, 14'h0AAA, 14'h0, 0,
                   0, 0, 14'h0, 3, 1'b1};
        tbl[7] = '{"illegal_7", 4'h7, 12'h3C3, 14'h1111, 14'h0, 0,
                   0, 0, 14'h0, 3, 1'b1};

        reset = 1'b1;
        data_write = 1'b0;
        complex_data = '0;
        ram_if.ram_garant = 1'b0;
        ram_if.ram_data_in = '0;
        tick();
        tick();
        check("reset ram_rd", ram_if.ram_rd, 0);
        check("reset ram_wr", ram_if.ram_wr, 0);
        check("reset ram_addr", ram_if.ram_addr, 0);
        check("reset ram_data", ram_if.ram_data_out, 0);
        check("reset pause", pause_DECODE, 0);
        check("reset busy", busy, 0);
        check("reset retired", retired, 0);
        check("reset err_illegal", err_illegal, 0);
        check("reset err_overflow", err_overflow, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);
        seq_overflow();
        seq_reset_mid();
        rand_run();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
